// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a 2-entry skid buffer, flush and a starvation counter.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_ctrl, in_data    upstream control bundle and payload
//   flush               synchronous squash of held and incoming entries
//   out_valid/out_ready downstream handshake
//   out_ctrl, out_data  downstream control bundle (NOP on bubbles) and payload
//   bubble_cnt          saturating count of cycles downstream was ready but starved
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 11,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              m_valid, s_valid, m_valid_n, s_valid_n;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] m_data, s_data, m_data_n, s_data_n;
    logic              accept, m_free;

    assign accept    = in_valid & in_ready;
    assign m_free    = !m_valid | out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_NOP;
    assign out_data  = m_data;

    always_comb begin
        m_valid_n = m_valid;
        m_ctrl_n  = m_ctrl;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_ctrl_n  = s_ctrl;
        s_data_n  = s_data;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
            m_ctrl_n  = CTRL_NOP;
            s_ctrl_n  = CTRL_NOP;
        end else if (m_free) begin
            // A full skid register always drains first; in_ready is low then, so no accept collides.
            if (s_valid) begin
                m_valid_n = 1'b1;
                m_ctrl_n  = s_ctrl;
                m_data_n  = s_data;
                s_valid_n = 1'b0;
            end else begin
                m_valid_n = accept;
                m_ctrl_n  = accept ? in_ctrl : m_ctrl;
                m_data_n  = accept ? in_data : m_data;
            end
        end else if (accept) begin
            s_valid_n = 1'b1;
            s_ctrl_n  = in_ctrl;
            s_data_n  = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            m_ctrl     <= CTRL_NOP;
            s_ctrl     <= CTRL_NOP;
            m_data     <= '0;
            s_data     <= '0;
            in_ready   <= 1'b1;
            bubble_cnt <= '0;
        end else begin
            m_valid  <= m_valid_n;
            s_valid  <= s_valid_n;
            m_ctrl   <= m_ctrl_n;
            s_ctrl   <= s_ctrl_n;
            m_data   <= m_data_n;
            s_data   <= s_data_n;
            // Registered from the next skid state, so out_ready never reaches in_ready combinationally.
            in_ready <= !s_valid_n;
            if (out_ready && !m_valid && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule
